cpu_bus_arbiter: RTL and testbench

Two-port arbiter that shares the CPU's single memory bus between the instruction fetch path (icache/fetch bus port) and the data path (load/store unit).
- Grants the bus to one requester per transaction.
- Data has priority, with a starvation guard so fetch always makes progress.
- Sits between the fetch and memory stages and the external bus master interface.

---
 rtl/cpu_bus_arbiter_if.sv | 46 ++++
 rtl/cpu_bus_arbiter.sv | 106 ++++++++++
 tb/tb_cpu_bus_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_bus_arbiter_if.sv
// Signal bundle between the fetch/load-store requesters, the arbiter and the external bus.
// The arbiter takes the master view; the surrounding requesters and bus model take the slave view.
interface cpu_bus_arbiter_if;
    logic        i_ibus_request;
    logic [31:0] i_ibus_address;
    logic        o_ibus_ready;
    logic [31:0] o_ibus_rdata;

    logic        i_dbus_request;
    logic        i_dbus_rw;
    logic [31:0] i_dbus_address;
    logic [31:0] i_dbus_wdata;
    logic [3:0]  i_dbus_wmask;
    logic        o_dbus_ready;
    logic [31:0] o_dbus_rdata;

    logic        o_bus_request;
    logic        o_bus_rw;
    logic [31:0] o_bus_address;
    logic [31:0] o_bus_wdata;
    logic [3:0]  o_bus_wmask;
    logic        i_bus_ready;
    logic [31:0] i_bus_rdata;

    logic [1:0]  o_grant;

    modport master (
        input  i_ibus_request, i_ibus_address,
        output o_ibus_ready, o_ibus_rdata,
        input  i_dbus_request, i_dbus_rw, i_dbus_address, i_dbus_wdata, i_dbus_wmask,
        output o_dbus_ready, o_dbus_rdata,
        output o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata, o_bus_wmask,
        input  i_bus_ready, i_bus_rdata,
        output o_grant
    );

    modport slave (
        output i_ibus_request, i_ibus_address,
        input  o_ibus_ready, o_ibus_rdata,
        output i_dbus_request, i_dbus_rw, i_dbus_address, i_dbus_wdata, i_dbus_wmask,
        input  o_dbus_ready, o_dbus_rdata,
        input  o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata, o_bus_wmask,
        output i_bus_ready, i_bus_rdata,
        input  o_grant
    );
endinterface

// File: rtl/cpu_bus_arbiter.sv
// Shares the single memory bus between instruction fetch and the load/store unit.
// Data wins ties unless fetch has lost STARVE_LIMIT cycles in a row.
module cpu_bus_arbiter #(
    parameter int STARVE_LIMIT = 8
) (
    input logic              i_clock,
    input logic              i_reset,
    cpu_bus_arbiter_if.master arb
);

    localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    // State encoding doubles as the o_grant value.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BUS_I = 2'b01,
        BUS_D = 2'b10
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] starve_count;
    logic          starved;
    logic          grant_i;
    logic          grant_d;
    logic          ibus_ready;
    logic          dbus_ready;

    assign starved = (STARVE_LIMIT != 0) && (starve_count >= LIMIT);

    always_comb begin
        state_d    = state_q;
        ibus_ready = 1'b0;
        dbus_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb.i_dbus_request && !(arb.i_ibus_request && starved))
                    state_d = BUS_D;
                else if (arb.i_ibus_request)
                    state_d = BUS_I;
            end
            BUS_I: begin
                if (arb.i_bus_ready) begin
                    ibus_ready = 1'b1;
                    state_d    = IDLE;
                end
            end
            BUS_D: begin
                if (arb.i_bus_ready) begin
                    dbus_ready = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant_i = (state_q == IDLE) && (state_d == BUS_I);
    assign grant_d = (state_q == IDLE) && (state_d == BUS_D);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= IDLE;
            starve_count <= '0;
        end else begin
            state_q <= state_d;
            if (grant_i)
                starve_count <= '0;
            else if (arb.i_ibus_request && (state_q != BUS_I) && (starve_count < LIMIT))
                starve_count <= starve_count + 1'b1;
        end
    end

    // Bus-side registers latch the winner's request at grant and hold until completion.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            arb.o_bus_request <= 1'b0;
            arb.o_bus_rw      <= 1'b0;
            arb.o_bus_address <= '0;
            arb.o_bus_wdata   <= '0;
            arb.o_bus_wmask   <= '0;
        end else if (grant_i) begin
            arb.o_bus_request <= 1'b1;
            arb.o_bus_rw      <= 1'b0;
            arb.o_bus_address <= arb.i_ibus_address;
            arb.o_bus_wdata   <= '0;
            arb.o_bus_wmask   <= '0;
        end else if (grant_d) begin
            arb.o_bus_request <= 1'b1;
            arb.o_bus_rw      <= arb.i_dbus_rw;
            arb.o_bus_address <= arb.i_dbus_address;
            arb.o_bus_wdata   <= arb.i_dbus_wdata;
            arb.o_bus_wmask   <= arb.i_dbus_wmask;
        end else if (ibus_ready || dbus_ready) begin
            arb.o_bus_request <= 1'b0;
        end
    end

    assign arb.o_ibus_ready = ibus_ready;
    assign arb.o_dbus_ready = dbus_ready;
    assign arb.o_ibus_rdata = arb.i_bus_rdata;
    assign arb.o_dbus_rdata = arb.i_bus_rdata;
    assign arb.o_grant      = state_q;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed testbench for cpu_bus_arbiter with STARVE_LIMIT = 4.
module tb_cpu_bus_arbiter;

    logic i_clock;
    logic i_reset;
    int   checks;
    int   passes;

    cpu_bus_arbiter_if bus_if ();

    cpu_bus_arbiter #(.STARVE_LIMIT(4)) dut (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .arb     (bus_if.master)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    task automatic tick();
        @(negedge i_clock);
    endtask

    task automatic clear_inputs();
        bus_if.i_ibus_request = 1'b0;
        bus_if.i_ibus_address = '0;
        bus_if.i_dbus_request = 1'b0;
        bus_if.i_dbus_rw      = 1'b0;
        bus_if.i_dbus_address = '0;
        bus_if.i_dbus_wdata   = '0;
        bus_if.i_dbus_wmask   = '0;
        bus_if.i_bus_ready    = 1'b0;
        bus_if.i_bus_rdata    = '0;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        i_reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        checks++; if (bus_if.o_bus_request !== 1'b0) $display("FAIL rst_bus_request got %b exp 0", bus_if.o_bus_request); else passes++;
        checks++; if (bus_if.o_bus_rw !== 1'b0) $display("FAIL rst_bus_rw got %b exp 0", bus_if.o_bus_rw); else passes++;
        checks++; if (bus_if.o_bus_address !== 32'h0) $display("FAIL rst_bus_address got %h exp 0", bus_if.o_bus_address); else passes++;
        checks++; if (bus_if.o_bus_wdata !== 32'h0) $display("FAIL rst_bus_wdata got %h exp 0", bus_if.o_bus_wdata); else passes++;
        checks++; if (bus_if.o_bus_wmask !== 4'h0) $display("FAIL rst_bus_wmask got %h exp 0", bus_if.o_bus_wmask); else passes++;
        checks++; if (bus_if.o_grant !== 2'b00) $display("FAIL rst_grant got %b exp 00", bus_if.o_grant); else passes++;
        i_reset = 1'b0;
        tick();
    endtask

    task automatic test_instr_read();
        bus_if.i_ibus_request = 1'b1;
        bus_if.i_ibus_address = 32'h0000_0100;
        #1;
        checks++; if (bus_if.o_bus_request !== 1'b0) $display("FAIL ird_req_early got %b exp 0", bus_if.o_bus_request); else passes++;
        tick();
        checks++; if (bus_if.o_bus_request !== 1'b1) $display("FAIL ird_req got %b exp 1", bus_if.o_bus_request); else passes++;
        checks++; if (bus_if.o_grant !== 2'b01) $display("FAIL ird_grant got %b exp 01", bus_if.o_grant); else passes++;
        checks++; if (bus_if.o_bus_address !== 32'h0000_0100) $display("FAIL ird_addr got %h exp 00000100", bus_if.o_bus_address); else passes++;
        checks++; if (bus_if.o_bus_rw !== 1'b0) $display("FAIL ird_rw got %b exp 0", bus_if.o_bus_rw); else passes++;
        checks++; if (bus_if.o_bus_wmask !== 4'h0) $display("FAIL ird_wmask got %h exp 0", bus_if.o_bus_wmask); else passes++;
        tick();
        tick();
        checks++; if (bus_if.o_ibus_ready !== 1'b0) $display("FAIL ird_ready_wait got %b exp 0", bus_if.o_ibus_ready); else passes++;
        tick();
        bus_if.i_bus_ready = 1'b1;
        bus_if.i_bus_rdata = 32'h0000_0013;
        #1;
        checks++; if (bus_if.o_ibus_ready !== 1'b1) $display("FAIL ird_ready got %b exp 1", bus_if.o_ibus_ready); else passes++;
        checks++; if (bus_if.o_ibus_rdata !== 32'h0000_0013) $display("FAIL ird_rdata got %h exp 00000013", bus_if.o_ibus_rdata); else passes++;
        checks++; if (bus_if.o_dbus_ready !== 1'b0) $display("FAIL ird_dready got %b exp 0", bus_if.o_dbus_ready); else passes++;
        tick();
        bus_if.i_ibus_request = 1'b0;
        bus_if.i_bus_ready    = 1'b0;
        #1;
        checks++; if (bus_if.o_grant !== 2'b00) $display("FAIL ird_grant_done got %b exp 00", bus_if.o_grant); else passes++;
        checks++; if (bus_if.o_bus_request !== 1'b0) $display("FAIL ird_req_done got %b exp 0", bus_if.o_bus_request); else passes++;
        checks++; if (bus_if.o_ibus_ready !== 1'b0) $display("FAIL ird_ready_once got %b exp 0", bus_if.o_ibus_ready); else passes++;
        tick();
    endtask

    task automatic test_data_write();
        bus_if.i_dbus_request = 1'b1;
        bus_if.i_dbus_rw      = 1'b1;
        bus_if.i_dbus_address = 32'h2000_0004;
        bus_if.i_dbus_wdata   = 32'hDEAD_BEEF;
        bus_if.i_dbus_wmask   = 4'hF;
        tick();
        checks++; if (bus_if.o_grant !== 2'b10) $display("FAIL dwr_grant got %b exp 10", bus_if.o_grant); else passes++;
        checks++; if (bus_if.o_bus_rw !== 1'b1) $display("FAIL dwr_rw got %b exp 1", bus_if.o_bus_rw); else passes++;
        checks++; if (bus_if.o_bus_address !== 32'h2000_0004) $display("FAIL dwr_addr got %h exp 20000004", bus_if.o_bus_address); else passes++;
        checks++; if (bus_if.o_bus_wdata !== 32'hDEAD_BEEF) $display("FAIL dwr_wdata got %h exp deadbeef", bus_if.o_bus_wdata); else passes++;
        checks++; if (bus_if.o_bus_wmask !== 4'hF) $display("FAIL dwr_wmask got %h exp f", bus_if.o_bus_wmask); else passes++;
        bus_if.i_dbus_address = 32'h1234_5678;
        bus_if.i_dbus_wdata   = 32'h0BAD_F00D;
        tick();
        checks++; if (bus_if.o_bus_address !== 32'h2000_0004) $display("FAIL dwr_addr_held got %h exp 20000004", bus_if.o_bus_address); else passes++;
        checks++; if (bus_if.o_bus_wdata !== 32'hDEAD_BEEF) $display("FAIL dwr_wdata_held got %h exp deadbeef", bus_if.o_bus_wdata); else passes++;
        bus_if.i_bus_ready = 1'b1;
        #1;
        checks++; if (bus_if.o_dbus_ready !== 1'b1) $display("FAIL dwr_ready got %b exp 1", bus_if.o_dbus_ready); else passes++;
        checks++; if (bus_if.o_ibus_ready !== 1'b0) $display("FAIL dwr_iready got %b exp 0", bus_if.o_ibus_ready); else passes++;
        tick();
        clear_inputs();
        #1;
        checks++; if (bus_if.o_grant !== 2'b00) $display("FAIL dwr_grant_done got %b exp 00", bus_if.o_grant); else passes++;
        checks++; if (bus_if.o_dbus_ready !== 1'b0) $display("FAIL dwr_ready_once got %b exp 0", bus_if.o_dbus_ready); else passes++;
        tick();
    endtask

    task automatic test_simultaneous();
        do_reset();
        bus_if.i_ibus_request = 1'b1;
        bus_if.i_ibus_address = 32'h0000_0200;
        bus_if.i_dbus_request = 1'b1;
        bus_if.i_dbus_rw      = 1'b0;
        bus_if.i_dbus_address = 32'h3000_0000;
        tick();
        checks++; if (bus_if.o_grant !== 2'b10) $display("FAIL sim_first_grant got %b exp 10", bus_if.o_grant); else passes++;
        checks++; if (bus_if.o_bus_address !== 32'h3000_0000) $display("FAIL sim_first_addr got %h exp 30000000", bus_if.o_bus_address); else passes++;
        bus_if.i_bus_ready = 1'b1;
        bus_if.i_bus_rdata = 32'h0000_0055;
        #1;
        checks++; if (bus_if.o_dbus_ready !== 1'b1) $display("FAIL sim_dready got %b exp 1", bus_if.o_dbus_ready); else passes++;
        checks++; if (bus_if.o_dbus_rdata !== 32'h0000_0055) $display("FAIL sim_drdata got %h exp 00000055", bus_if.o_dbus_rdata); else passes++;
        checks++; if (bus_if.o_ibus_ready !== 1'b0) $display("FAIL sim_iready_early got %b exp 0", bus_if.o_ibus_ready); else passes++;
        tick();
        bus_if.i_dbus_request = 1'b0;
        bus_if.i_bus_ready    = 1'b0;
        #1;
        checks++; if (bus_if.o_grant !== 2'b00) $display("FAIL sim_turnaround got %b exp 00", bus_if.o_grant); else passes++;
        tick();
        checks++; if (bus_if.o_grant !== 2'b01) $display("FAIL sim_second_grant got %b exp 01", bus_if.o_grant); else passes++;
        checks++; if (bus_if.o_bus_address !== 32'h0000_0200) $display("FAIL sim_second_addr got %h exp 00000200", bus_if.o_bus_address); else passes++;
        bus_if.i_bus_ready = 1'b1;
        bus_if.i_bus_rdata = 32'h0000_0077;
        #1;
        checks++; if (bus_if.o_ibus_ready !== 1'b1) $display("FAIL sim_iready got %b exp 1", bus_if.o_ibus_ready); else passes++;
        checks++; if (bus_if.o_ibus_rdata !== 32'h0000_0077) $display("FAIL sim_irdata got %h exp 00000077", bus_if.o_ibus_rdata); else passes++;
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_starvation();
        do_reset();
        bus_if.i_ibus_request = 1'b1;
        bus_if.i_ibus_address = 32'h0000_0400;
        bus_if.i_dbus_request = 1'b1;
        bus_if.i_dbus_address = 32'h5000_0000;
        for (int t = 0; t < 2; t++) begin
            tick();
            checks++; if (bus_if.o_grant !== 2'b10) $display("FAIL stv_data_grant%0d got %b exp 10", t, bus_if.o_grant); else passes++;
            bus_if.i_bus_ready = 1'b1;
            tick();
            bus_if.i_bus_ready = 1'b0;
        end
        checks++; if (int'(dut.starve_count) !== 4) $display("FAIL stv_count_full got %0d exp 4", dut.starve_count); else passes++;
        tick();
        checks++; if (bus_if.o_grant !== 2'b01) $display("FAIL stv_forced_grant got %b exp 01", bus_if.o_grant); else passes++;
        checks++; if (bus_if.o_bus_address !== 32'h0000_0400) $display("FAIL stv_forced_addr got %h exp 00000400", bus_if.o_bus_address); else passes++;
        checks++; if (int'(dut.starve_count) !== 0) $display("FAIL stv_count_clear got %0d exp 0", dut.starve_count); else passes++;
        bus_if.i_bus_ready = 1'b1;
        #1;
        checks++; if (bus_if.o_ibus_ready !== 1'b1) $display("FAIL stv_iready got %b exp 1", bus_if.o_ibus_ready); else passes++;
        tick();
        clear_inputs();
        tick();
        checks++; if (bus_if.o_grant !== 2'b00) $display("FAIL stv_idle got %b exp 00", bus_if.o_grant); else passes++;
    endtask

    task automatic test_reset_mid();
        bus_if.i_dbus_request = 1'b1;
        bus_if.i_dbus_address = 32'h4000_0000;
        tick();
        checks++; if (bus_if.o_bus_request !== 1'b1) $display("FAIL rmid_req_before got %b exp 1", bus_if.o_bus_request); else passes++;
        #2;
        i_reset = 1'b1;
        #1;
        checks++; if (bus_if.o_bus_request !== 1'b0) $display("FAIL rmid_req_async got %b exp 0", bus_if.o_bus_request); else passes++;
        checks++; if (bus_if.o_grant !== 2'b00) $display("FAIL rmid_grant got %b exp 00", bus_if.o_grant); else passes++;
        bus_if.i_bus_ready = 1'b1;
        #1;
        checks++; if (bus_if.o_dbus_ready !== 1'b0) $display("FAIL rmid_dready got %b exp 0", bus_if.o_dbus_ready); else passes++;
        tick();
        clear_inputs();
        i_reset = 1'b0;
        bus_if.i_ibus_request = 1'b1;
        bus_if.i_ibus_address = 32'h0000_0600;
        tick();
        checks++; if (bus_if.o_grant !== 2'b01) $display("FAIL rmid_fresh_grant got %b exp 01", bus_if.o_grant); else passes++;
        checks++; if (bus_if.o_bus_address !== 32'h0000_0600) $display("FAIL rmid_fresh_addr got %h exp 00000600", bus_if.o_bus_address); else passes++;
        bus_if.i_bus_ready = 1'b1;
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_spurious_ready();
        bus_if.i_bus_ready = 1'b1;
        bus_if.i_bus_rdata = 32'hFFFF_FFFF;
        #1;
        checks++; if (bus_if.o_ibus_ready !== 1'b0) $display("FAIL spur_iready got %b exp 0", bus_if.o_ibus_ready); else passes++;
        checks++; if (bus_if.o_dbus_ready !== 1'b0) $display("FAIL spur_dready got %b exp 0", bus_if.o_dbus_ready); else passes++;
        tick();
        checks++; if (bus_if.o_grant !== 2'b00) $display("FAIL spur_grant got %b exp 00", bus_if.o_grant); else passes++;
        checks++; if (bus_if.o_bus_request !== 1'b0) $display("FAIL spur_req got %b exp 0", bus_if.o_bus_request); else passes++;
        bus_if.i_bus_ready = 1'b0;
        tick();
    endtask

    initial begin
        checks = 0;
        passes = 0;
        i_reset = 1'b1;
        clear_inputs();
        test_reset();
        test_instr_read();
        test_data_write();
        test_simultaneous();
        test_starvation();
        test_reset_mid();
        test_spurious_ready();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
